// File: rtl/serial_frame_transmitter.sv
// Framed serial transmitter: start bit, data (LSB- or MSB-first), optional parity, 1-2 stop bits.
// A one-word holding buffer with valid/ready lets frames be sent back-to-back with no gap.
module serial_frame_transmitter #(
  parameter int DATA_WIDTH = 8,
  parameter int LSB_FIRST  = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  transmission_clock,
  input  logic                  send,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  ready,
  output logic                  transmission,
  output logic                  out_data,
  output logic                  frame_done
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
    $error("serial_frame_transmitter: STOP_BITS must be 1 or 2");
  end
  if ((DATA_WIDTH < 1) || (DATA_WIDTH > 32)) begin : g_bad_data_width
    $error("serial_frame_transmitter: DATA_WIDTH must be in 1..32");
  end

  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] word);
    if (PARITY_ODD != 0) begin
      return ~(^word);
    end else begin
      return ^word;
    end
  endfunction

  function automatic logic line_level(input state_e st, input logic [DATA_WIDTH-1:0] sh,
                                      input logic par);
    case (st)
      ST_IDLE:   return 1'b1;
      ST_START:  return 1'b0;
      ST_DATA:   return (LSB_FIRST != 0) ? sh[0] : sh[DATA_WIDTH-1];
      ST_PARITY: return par;
      ST_STOP:   return 1'b1;
      default:   return 1'b1;
    endcase
  endfunction

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic                  parity_q, parity_d;
  logic                  hold_valid_q, hold_valid_d;
  logic                  out_q, out_d;
  logic                  done_q, done_d;

  logic                  accept_s;
  logic                  final_tick_s;
  logic                  load_s;
  logic [DATA_WIDTH-1:0] load_word_s;

  assign ready        = ~hold_valid_q;
  assign transmission = (state_q != ST_IDLE);
  assign out_data     = out_q;
  assign frame_done   = done_q;

  // Next-state, buffer and line-level logic for the frame sequencer.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    hold_d       = hold_q;
    bit_cnt_d    = bit_cnt_q;
    stop_cnt_d   = stop_cnt_q;
    parity_d     = parity_q;
    hold_valid_d = hold_valid_q;
    done_d       = 1'b0;
    load_s       = 1'b0;
    load_word_s  = in_data;

    accept_s     = send & ready;
    final_tick_s = (state_q == ST_STOP) && transmission_clock && (stop_cnt_q == STOP_LAST);

    // Busy accepts land in the holding buffer; an accept on the final stop tick starts directly.
    if (accept_s && (state_q != ST_IDLE) && !final_tick_s) begin
      hold_d       = in_data;
      hold_valid_d = 1'b1;
    end else begin
      hold_valid_d = hold_valid_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          load_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (transmission_clock) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (transmission_clock) begin
          shift_d = (LSB_FIRST != 0) ? (shift_q >> 1'b1) : (shift_q << 1'b1);
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1'b1);
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (transmission_clock) begin
          state_d = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (final_tick_s) begin
          stop_cnt_d = 1'b0;
          done_d     = 1'b1;
          if (hold_valid_q) begin
            load_s       = 1'b1;
            load_word_s  = hold_q;
            hold_valid_d = 1'b0;
          end else if (send) begin
            load_s = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (transmission_clock) begin
          stop_cnt_d = ~stop_cnt_q;
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (load_s) begin
      state_d    = ST_START;
      shift_d    = load_word_s;
      parity_d   = calc_parity(load_word_s);
      bit_cnt_d  = '0;
      stop_cnt_d = 1'b0;
    end else begin
      parity_d = parity_q;
    end

    // The line register follows the level of the state being entered, so a new bit appears on its first edge.
    out_d = line_level(state_d, shift_d, parity_d);
  end

  // Frame sequencer, holding buffer and registered line outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      hold_q       <= '0;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= 1'b0;
      parity_q     <= 1'b0;
      hold_valid_q <= 1'b0;
      out_q        <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      parity_q     <= parity_d;
      hold_valid_q <= hold_valid_d;
      out_q        <= out_d;
      done_q       <= done_d;
    end
  end

endmodule

// File: tb/tb_serial_frame_transmitter.sv
// Directed bench for serial_frame_transmitter: four parameter variants share clock, reset and strobe.
// The line is sampled once per bit period (just before each strobed edge) into a per-instance history.
module tb_serial_frame_transmitter;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       snd [4];
  logic [7:0] din [4];
  logic       rdy [4];
  logic       tx  [4];
  logic       od  [4];
  logic       fd  [4];

  int tests = 0;
  int fails = 0;

  logic hist [4][512];
  int   hcnt [4];
  int   dcnt [4];

  typedef struct {
    int          dut;
    logic [7:0]  data;
    logic [31:0] exp;
    int          len;
  } vec_t;

  vec_t vecs [9];

  always #5 clk = ~clk;

  serial_frame_transmitter u0 (
    .clk(clk), .rst(rst), .transmission_clock(tick), .send(snd[0]), .in_data(din[0]),
    .ready(rdy[0]), .transmission(tx[0]), .out_data(od[0]), .frame_done(fd[0]));

  serial_frame_transmitter #(.PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .clk(clk), .rst(rst), .transmission_clock(tick), .send(snd[1]), .in_data(din[1]),
    .ready(rdy[1]), .transmission(tx[1]), .out_data(od[1]), .frame_done(fd[1]));

  serial_frame_transmitter #(.PARITY_EN(1), .PARITY_ODD(1)) u2 (
    .clk(clk), .rst(rst), .transmission_clock(tick), .send(snd[2]), .in_data(din[2]),
    .ready(rdy[2]), .transmission(tx[2]), .out_data(od[2]), .frame_done(fd[2]));

  serial_frame_transmitter #(.DATA_WIDTH(5), .LSB_FIRST(0), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .transmission_clock(tick), .send(snd[3]), .in_data(din[3][4:0]),
    .ready(rdy[3]), .transmission(tx[3]), .out_data(od[3]), .frame_done(fd[3]));

  // Strobe generator (every 4th clk) and per-bit-period line monitor.
  initial begin
    int phase;
    phase = 0;
    tick  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      hcnt[i] = 0;
      dcnt[i] = 0;
    end
    forever begin
      @(negedge clk);
      tick  = (phase == 3);
      phase = (phase + 1) % 4;
      for (int i = 0; i < 4; i++) begin
        if (tx[i] && tick && hcnt[i] < 512) begin
          hist[i][hcnt[i]] = od[i];
          hcnt[i]++;
        end
        if (fd[i]) dcnt[i]++;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_word(input int d, input logic [7:0] v);
    @(negedge clk);
    din[d] = v;
    snd[d] = 1'b1;
    @(negedge clk);
    snd[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, input int target, input string name);
    int g;
    g = 0;
    while (dcnt[d] < target && g < 400) begin
      @(negedge clk);
      g++;
    end
    if (dcnt[d] < target) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: frame_done count %0d, expected %0d", name, dcnt[d], target);
    end
  endtask

  task automatic grab(input int d, input int base, output int n, output logic [31:0] act);
    n   = hcnt[d] - base;
    act = '0;
    for (int k = 0; k < n && k < 32; k++) act[k] = hist[d][base + k];
  endtask

  task automatic check_frame(input int d, input logic [7:0] v, input logic [31:0] exp,
                             input int len, input string name);
    int base, d0, n;
    logic [31:0] act;
    base = hcnt[d];
    d0   = dcnt[d];
    send_word(d, v);
    wait_done(d, d0 + 1, name);
    repeat (3) @(negedge clk);
    grab(d, base, n, act);
    chk({name, " len"}, 32'(n), 32'(len));
    chk({name, " bits"}, act, exp);
    chk({name, " done"}, 32'(dcnt[d] - d0), 32'd1);
    chk({name, " idle"}, {31'd0, tx[d]}, 32'd0);
  endtask

  initial begin
    int base, db, n, g;
    logic [31:0] act;

    // bit k of exp = line level in bit period k (k=0 is the start bit)
    vecs[0] = '{0, 8'hA5, 32'h34A, 10};
    vecs[1] = '{0, 8'h00, 32'h200, 10};
    vecs[2] = '{0, 8'hFF, 32'h3FE, 10};
    vecs[3] = '{1, 8'h07, 32'h60E, 11};
    vecs[4] = '{2, 8'h07, 32'h40E, 11};
    vecs[5] = '{1, 8'h03, 32'h406, 11};
    vecs[6] = '{2, 8'h00, 32'h600, 11};
    vecs[7] = '{3, 8'h13, 32'h0F2, 8};
    vecs[8] = '{3, 8'h01, 32'h0E0, 8};

    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      snd[i] = 1'b0;
      din[i] = 8'h00;
    end

    // reset held with random inputs: {out_data, transmission, ready, frame_done} must be 1010
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("reset hold u%0d c%0d", i, c), {28'd0, od[i], tx[i], rdy[i], fd[i]}, 32'hA);
        snd[i] = 1'($urandom_range(0, 1));
        din[i] = 8'($urandom);
      end
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) snd[i] = 1'b0;
    rst = 1'b1;
    repeat (30) @(negedge clk);
    for (int i = 0; i < 4; i++)
      chk($sformatf("idle after reset u%0d", i), {28'd0, od[i], tx[i], rdy[i], fd[i]}, 32'hA);

    for (int v = 0; v < 9; v++)
      check_frame(vecs[v].dut, vecs[v].data, vecs[v].exp, vecs[v].len, $sformatf("vec%0d", v));

    // back-to-back: 0x12, then 0x34 held during DATA, then 0x56 offered while not ready
    base = hcnt[0];
    db   = dcnt[0];
    send_word(0, 8'h12);
    repeat (8) @(negedge clk);
    send_word(0, 8'h34);
    chk("b2b ready low after hold", {31'd0, rdy[0]}, 32'd0);
    din[0] = 8'h56;
    snd[0] = 1'b1;
    @(negedge clk);
    snd[0] = 1'b0;
    chk("b2b ready low after ignored send", {31'd0, rdy[0]}, 32'd0);
    wait_done(0, db + 2, "b2b");
    repeat (3) @(negedge clk);
    grab(0, base, n, act);
    chk("b2b len", 32'(n), 32'd20);
    chk("b2b bits", act, 32'h9A224);
    chk("b2b done", 32'(dcnt[0] - db), 32'd2);
    chk("b2b ready high", {31'd0, rdy[0]}, 32'd1);
    chk("b2b idle", {31'd0, tx[0]}, 32'd0);

    // reset during the third data bit of 0x3C with 0x99 held
    base = hcnt[0];
    db   = dcnt[0];
    send_word(0, 8'h3C);
    send_word(0, 8'h99);
    chk("rst-mid ready low", {31'd0, rdy[0]}, 32'd0);
    g = 0;
    while (hcnt[0] < base + 3 && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("rst-mid reached data bit 2", {31'd0, hcnt[0] >= base + 3}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst-mid async outputs", {28'd0, od[0], tx[0], rdy[0], fd[0]}, 32'hA);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst-mid stays idle", {28'd0, od[0], tx[0], rdy[0], fd[0]}, 32'hA);
    chk("rst-mid no frame_done", 32'(dcnt[0] - db), 32'd0);
    check_frame(0, 8'h81, 32'h302, 10, "after-reset 0x81");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_frame_transmitter.md
# serial_frame_transmitter

Parametrised framed serial transmitter, the successor to the 8-bit raw bit shifter. It adds start and stop framing, optional parity, bit order selection and a one-word holding buffer with a valid/ready handshake, so frames can be sent back-to-back without gaps. It sits between the byte-producing logic and the serial line, and is paced by the shared `transmission_clock` bit-rate strobe.

## Interface
- `DATA_WIDTH`, 8: payload bits per frame, legal range 1..32.
- `LSB_FIRST`, 1: 1 sends bit 0 first; 0 sends bit DATA_WIDTH-1 first.
- `PARITY_EN`, 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, 0: 0 selects even parity (XOR of the data bits); 1 selects odd parity (inverted XOR).
- `STOP_BITS`, 1: number of stop bits, 1 or 2. Any other value is an elaboration error.

- `clk`  in  1  single clock; everything is registered on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `transmission_clock`  in  1  bit-rate strobe, a one-`clk`-cycle enable.
- `send`  in  1  word valid.
- `in_data`  in  DATA_WIDTH  word to transmit, sampled on accept.
- `ready`  out  1  high when the holding buffer is empty; combinational from `hold_valid`.
- `transmission`  out  1  high while a frame is on the line (state is not IDLE).
- `out_data`  out  1  serial line, registered; idle level is 1.
- `frame_done`  out  1  one-cycle pulse after the last stop bit ends.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Line level per state:
  - IDLE: 1.
  - START: 0.
  - DATA: current shift-register bit.
  - PARITY: parity bit.
  - STOP: 1.
- Accept rule: a word is accepted on a `clk` edge where `send && ready`.
  - If state is IDLE, the word bypasses the holding buffer. It loads the shift register and parity, and the state becomes START.
  - Otherwise the word goes to the holding buffer and `hold_valid` is set, which drops `ready`.
  - `send` while `ready`=0 is ignored, and the held word is unchanged.
- Bit advance: the state or bit index advances only on an edge where `transmission_clock`=1 and the state is not IDLE.
  - DATA uses a bit counter of width clog2(DATA_WIDTH), with a minimum width of 1.
  - DATA exits after DATA_WIDTH ticks, to PARITY if PARITY_EN=1, else to STOP.
  - STOP counts STOP_BITS ticks.
- End of frame: on the final STOP tick, `frame_done` pulses on the next cycle.
  - If `hold_valid`=1, go directly to START with the held word and clear `hold_valid`. There is no idle bit between frames.
  - Else, if `send` is high in the same cycle, treat it as an IDLE accept and go to START with `in_data`.
  - Else go to IDLE.
- Parity is computed from the word at load time and stored. It is not recomputed while shifting.

## Timing
- Reset (`rst`=0, asynchronous) sets:
  - state to IDLE, `out_data`=1, `transmission`=0, `frame_done`=0;
  - `hold_valid`=0, so `ready`=1;
  - the shift register, counters and parity to 0.
- Reset has priority over all other inputs. Asserting it mid-frame aborts the frame immediately, and the line returns to 1 asynchronously.
- Accept latency: a word accepted at edge N while IDLE drives the start bit (`out_data`=0, `transmission`=1) from edge N.
- Bit period: each bit ends on the first strobed edge after it began. The first bit after an idle accept can therefore be shorter than a full strobe period, with a minimum of 1 `clk` cycle. Later bits are exactly one strobe period.
- Frame length: 1 + DATA_WIDTH + PARITY_EN + STOP_BITS bit periods.
- `ready` rises on the edge where the held word moves into the shift register.
- `transmission_clock` high while IDLE has no effect.

## Test plan
- Reset: hold `rst`=0 with random inputs. Required: `out_data`=1, `transmission`=0, `ready`=1, `frame_done`=0. Then release `rst` and confirm the block stays idle with `send`=0.
- Basic frame (defaults, strobe every 4 clk): send 0xA5. Required line sequence per bit period: 0, 1,0,1,0,0,1,0,1, 1. Also `transmission` high for 10 bit periods and exactly one `frame_done` pulse.
- Parity (`PARITY_EN`=1): send 0x07 with `PARITY_ODD`=0 and require parity bit 1. Repeat with `PARITY_ODD`=1 and require parity bit 0. Frame length is 11 bit periods in both cases.
- Back-to-back: send 0x12, then 0x34 during its DATA state; `ready` must drop. Then send 0x56 with `ready`=0; it must be ignored. Required: 0x34's start bit immediately follows 0x12's stop bit, `ready` returns to 1, two `frame_done` pulses, and 0x56 is never sent.
- Reset mid-frame: assert `rst`=0 during the third data bit of 0x3C with 0x99 held. Required: `out_data`=1 and `transmission`=0 immediately, and the held word is discarded. After release, send 0x81 and require a correct frame.
- Variant (`DATA_WIDTH`=5, `LSB_FIRST`=0, `STOP_BITS`=2): send 0x13. Required line sequence: 0, 1,0,0,1,1, 1,1, for a frame of 8 bit periods.
